// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bus between the execute/memory requesters, the issue stage and the
// register-file write controller.
interface regfile_wb_ctrl_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [5*NREQ-1:0]      req_rd_i;
  logic [DATA_W*NREQ-1:0] req_dat_i;
  logic                   alloc_en_i;
  logic [4:0]             alloc_rd_i;
  logic                   wr_en_o;
  logic [4:0]             reg_des_o;
  logic [DATA_W-1:0]      reg_des_dat_o;
  logic [31:0]            busy_o;
  logic                   alloc_err_o;

  modport master (
    output req_valid_i, req_rd_i, req_dat_i, alloc_en_i, alloc_rd_i,
    input  req_ready_o, wr_en_o, reg_des_o, reg_des_dat_o, busy_o, alloc_err_o
  );

  modport slave (
    input  req_valid_i, req_rd_i, req_dat_i, alloc_en_i, alloc_rd_i,
    output req_ready_o, wr_en_o, reg_des_o, reg_des_dat_o, busy_o, alloc_err_o
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Round-robin arbiter for the register file's single write port, with a registered
// write stage and a per-register busy scoreboard for issue-stage stalls.
module regfile_wb_ctrl #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  regfile_wb_ctrl_if.slave wb
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [4:0]        gnt_rd;
  logic [DATA_W-1:0] gnt_dat;

  logic              wr_en_q, wr_en_d;
  logic [4:0]        reg_des_q, reg_des_d;
  logic [DATA_W-1:0] reg_des_dat_q, reg_des_dat_d;
  logic [31:0]       busy_q, busy_d;
  logic              alloc_err_q, alloc_err_d;
  logic              alloc_live;
  logic              clr_hit;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && wb.req_valid_i[(int'(ptr_q) + i) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    wb.req_ready_o = '0;
    if (gnt_vld) wb.req_ready_o[gnt_idx] = 1'b1;
  end

  assign gnt_rd  = wb.req_rd_i[5*int'(gnt_idx) +: 5];
  assign gnt_dat = wb.req_dat_i[DATA_W*int'(gnt_idx) +: DATA_W];

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
  end

  // x0 grants consume the slot but never strobe the file.
  always_comb begin
    wr_en_d       = gnt_vld && (gnt_rd != 5'd0);
    reg_des_d     = gnt_vld ? gnt_rd  : reg_des_q;
    reg_des_dat_d = gnt_vld ? gnt_dat : reg_des_dat_q;
  end

  // Clear lands on the same edge the file captures the data; a same-edge set wins.
  always_comb begin
    alloc_live = wb.alloc_en_i && (wb.alloc_rd_i != 5'd0);
    clr_hit    = wr_en_q && (reg_des_q == wb.alloc_rd_i);
    busy_d     = busy_q;
    if (wr_en_q)    busy_d[reg_des_q]     = 1'b0;
    if (alloc_live) busy_d[wb.alloc_rd_i] = 1'b1;
    busy_d[0]   = 1'b0;
    alloc_err_d = alloc_err_q | (alloc_live && busy_q[wb.alloc_rd_i] && !clr_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      wr_en_q       <= 1'b0;
      reg_des_q     <= '0;
      reg_des_dat_q <= '0;
      busy_q        <= '0;
      alloc_err_q   <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      wr_en_q       <= wr_en_d;
      reg_des_q     <= reg_des_d;
      reg_des_dat_q <= reg_des_dat_d;
      busy_q        <= busy_d;
      alloc_err_q   <= alloc_err_d;
    end
  end

  assign wb.wr_en_o       = wr_en_q;
  assign wb.reg_des_o     = reg_des_q;
  assign wb.reg_des_dat_o = reg_des_dat_q;
  assign wb.busy_o        = busy_q;
  assign wb.alloc_err_o   = alloc_err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed vectors with literal expectations, plus a
// per-cycle comparison against a behavioural model of the arbiter and scoreboard.
module tb_regfile_wb_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] rf [32] = '{default: 32'd0};

  regfile_wb_ctrl_if #(.NREQ(3), .DATA_W(32)) wb ();

  regfile_wb_ctrl #(.NREQ(3), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  always #5 clk = ~clk;

  // Stand-in register file fed from the write port.
  always @(posedge clk) if (wb.wr_en_o) rf[wb.reg_des_o] <= wb.reg_des_dat_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pick(input int p, input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[(p + i) % 3]) return (p + i) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready(input int g);
    logic [2:0] r;
    r = 3'b000;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] next_busy(input logic [31:0] b, input logic wr,
                                            input logic [4:0] d, input logic ae,
                                            input logic [4:0] ar);
    logic [31:0] n;
    n = b;
    if (wr) n[d] = 1'b0;
    if (ae && ar != 5'd0) n[ar] = 1'b1;
    return n;
  endfunction

  function automatic logic bad_alloc(input logic [31:0] b, input logic wr,
                                     input logic [4:0] d, input logic ae,
                                     input logic [4:0] ar);
    return ae && (ar != 5'd0) && b[ar] && !(wr && d == ar);
  endfunction

  int          m_ptr;
  int          mg;
  logic        m_wr;
  logic [4:0]  m_des;
  logic [31:0] m_dat;
  logic [31:0] m_busy;
  logic        m_err;

  always_comb mg = pick(m_ptr, wb.req_valid_i);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  <= 0;
      m_wr   <= 1'b0;
      m_des  <= 5'd0;
      m_dat  <= 32'd0;
      m_busy <= 32'd0;
      m_err  <= 1'b0;
    end else begin
      if (mg >= 0) begin
        m_ptr <= (mg + 1) % 3;
        m_wr  <= wb.req_rd_i[5*mg +: 5] != 5'd0;
        m_des <= wb.req_rd_i[5*mg +: 5];
        m_dat <= wb.req_dat_i[32*mg +: 32];
      end else begin
        m_wr <= 1'b0;
      end
      m_busy <= next_busy(m_busy, m_wr, m_des, wb.alloc_en_i, wb.alloc_rd_i);
      m_err  <= m_err | bad_alloc(m_busy, m_wr, m_des, wb.alloc_en_i, wb.alloc_rd_i);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_ready", 32'(wb.req_ready_o), 32'(exp_ready(mg)));
      chk("m_wr_en", 32'(wb.wr_en_o), 32'(m_wr));
      chk("m_reg_des", 32'(wb.reg_des_o), 32'(m_des));
      chk("m_reg_dat", wb.reg_des_dat_o, m_dat);
      chk("m_busy", wb.busy_o, m_busy);
      chk("m_alloc_err", 32'(wb.alloc_err_o), 32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] rd, input logic [31:0] dat);
    wb.req_rd_i[5*k +: 5]   = rd;
    wb.req_dat_i[32*k +: 32] = dat;
  endtask

  initial begin
    wb.req_valid_i = 3'b000;
    wb.req_rd_i    = '0;
    wb.req_dat_i   = '0;
    wb.alloc_en_i  = 1'b0;
    wb.alloc_rd_i  = 5'd0;
    #12 rst_n = 1'b1;
    step();
    #3;
    chk("rst_wr_en", 32'(wb.wr_en_o), 32'd0);
    chk("rst_reg_des", 32'(wb.reg_des_o), 32'd0);
    chk("rst_reg_dat", wb.reg_des_dat_o, 32'd0);
    chk("rst_busy", wb.busy_o, 32'd0);
    chk("rst_err", 32'(wb.alloc_err_o), 32'd0);
    chk("idle_ready", 32'(wb.req_ready_o), 32'd0);

    // Single requester
    step();
    set_req(0, 5'd5, 32'hDEADBEEF);
    wb.req_valid_i = 3'b001;
    #3 chk("single_ready", 32'(wb.req_ready_o), 32'b001);
    step();
    wb.req_valid_i = 3'b000;
    #3;
    chk("single_wr_en", 32'(wb.wr_en_o), 32'd1);
    chk("single_des", 32'(wb.reg_des_o), 32'd5);
    chk("single_dat", wb.reg_des_dat_o, 32'hDEADBEEF);
    step();
    #3 chk("single_rf_x5", rf[5], 32'hDEADBEEF);

    // x0 request from requester 2 (pointer sits at 1)
    step();
    set_req(2, 5'd0, 32'h12345678);
    wb.req_valid_i = 3'b100;
    #3 chk("x0_ready", 32'(wb.req_ready_o), 32'b100);
    step();
    wb.req_valid_i = 3'b000;
    #3 chk("x0_wr_en", 32'(wb.wr_en_o), 32'd0);

    // Fairness: pointer back at 0, all three hold valid
    step();
    set_req(0, 5'd10, 32'hA000_0000);
    set_req(1, 5'd11, 32'hA000_0001);
    set_req(2, 5'd12, 32'hA000_0002);
    wb.req_valid_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("fair_grant", 32'(wb.req_ready_o), 32'(3'b001 << (i % 3)));
      if (i > 0) chk("fair_wr_en", 32'(wb.wr_en_o), 32'd1);
      step();
    end
    wb.req_valid_i = 3'b000;
    #3 chk("fair_last_wr", 32'(wb.wr_en_o), 32'd1);

    // Scoreboard: plain set/clear (cycle 1 alloc, cycle 4 grant)
    step();
    wb.alloc_en_i = 1'b1; wb.alloc_rd_i = 5'd7;
    step();
    wb.alloc_en_i = 1'b0;
    #3 chk("sb_set7", 32'(wb.busy_o[7]), 32'd1);
    step();
    step();
    set_req(0, 5'd7, 32'h0000_0077);
    wb.req_valid_i = 3'b001;
    #3 chk("sb_grant", 32'(wb.req_ready_o), 32'b001);
    step();
    wb.req_valid_i = 3'b000;
    #3;
    chk("sb_busy_c5", 32'(wb.busy_o[7]), 32'd1);
    chk("sb_wr_c5", 32'(wb.wr_en_o), 32'd1);
    step();
    #3 chk("sb_clear_c6", 32'(wb.busy_o[7]), 32'd0);

    // Scoreboard: re-alloc coinciding with the clear
    step();
    wb.alloc_en_i = 1'b1; wb.alloc_rd_i = 5'd7;
    step();
    wb.alloc_en_i = 1'b0;
    step();
    wb.req_valid_i = 3'b001;
    step();
    wb.req_valid_i = 3'b000;
    wb.alloc_en_i = 1'b1; wb.alloc_rd_i = 5'd7;
    #3 chk("co_wr_en", 32'(wb.wr_en_o), 32'd1);
    step();
    wb.alloc_en_i = 1'b0;
    #3;
    chk("co_busy7", 32'(wb.busy_o[7]), 32'd1);
    chk("co_err", 32'(wb.alloc_err_o), 32'd0);
    step();
    wb.req_valid_i = 3'b001;
    step();
    wb.req_valid_i = 3'b000;
    step();
    step();
    #3 chk("co_cleared", wb.busy_o, 32'd0);

    // Write-back to a non-busy register
    set_req(0, 5'd20, 32'hCAFE_0020);
    wb.req_valid_i = 3'b001;
    step();
    wb.req_valid_i = 3'b000;
    step();
    #3;
    chk("nb_busy", wb.busy_o, 32'd0);
    chk("nb_rf_x20", rf[20], 32'hCAFE_0020);

    // Allocating x0 is ignored
    wb.alloc_en_i = 1'b1; wb.alloc_rd_i = 5'd0;
    step();
    wb.alloc_en_i = 1'b0;
    #3 chk("alloc_x0_busy", wb.busy_o, 32'd0);

    // Double alloc of x3 -> sticky error
    wb.alloc_en_i = 1'b1; wb.alloc_rd_i = 5'd3;
    step();
    #3 chk("dbl_err_first", 32'(wb.alloc_err_o), 32'd0);
    step();
    wb.alloc_en_i = 1'b0;
    #3 chk("dbl_err_set", 32'(wb.alloc_err_o), 32'd1);
    step();
    step();
    #3;
    chk("dbl_err_sticky", 32'(wb.alloc_err_o), 32'd1);
    chk("dbl_busy3", wb.busy_o, 32'h0000_0008);

    // Reset in the middle of a write to x9
    wb.alloc_en_i = 1'b1; wb.alloc_rd_i = 5'd9;
    step();
    wb.alloc_en_i = 1'b0;
    set_req(0, 5'd9, 32'h0000_0999);
    wb.req_valid_i = 3'b001;
    #3 chk("rw_ready", 32'(wb.req_ready_o), 32'b001);
    step();
    wb.req_valid_i = 3'b000;
    #1;
    chk("rw_wr_before", 32'(wb.wr_en_o), 32'd1);
    chk("rw_busy9_before", 32'(wb.busy_o[9]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_wr_async", 32'(wb.wr_en_o), 32'd0);
    chk("rw_busy_async", wb.busy_o, 32'd0);
    chk("rw_des_async", 32'(wb.reg_des_o), 32'd0);
    chk("rw_err_async", 32'(wb.alloc_err_o), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    set_req(0, 5'd13, 32'hB000_0000);
    set_req(1, 5'd14, 32'hB000_0001);
    set_req(2, 5'd15, 32'hB000_0002);
    wb.req_valid_i = 3'b111;
    #3 chk("rw_ptr_reset", 32'(wb.req_ready_o), 32'b001);
    step();
    wb.req_valid_i = 3'b000;
    step();
    step();
    #3 chk("rw_rf_x9", rf[9], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32x32 register file. It shares the file's single write port between NREQ write-back requesters (ALU, LSU, MUL/DIV) using round-robin arbitration and valid/ready handshakes. It registers the winning write onto the port and keeps a per-register busy scoreboard, which the issue stage uses to stall on pending writes. It sits between the execute/memory units and the register file's wr_en / reg_des_i / reg_des_dat_i inputs.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  NREQ  requester k has a write pending
- req_ready_o  out  NREQ  requester k granted this cycle (one-hot or zero)
- req_rd_i  in  5*NREQ  destination register; requester k at [5k+4:5k]
- req_dat_i  in  32*NREQ  write data; requester k at [32k+31:32k]
- alloc_en_i  in  1  issue stage claims a destination register this cycle
- alloc_rd_i  in  5  register being claimed
- wr_en_o  out  1  to register file wr_en
- reg_des_o  out  5  to register file reg_des_i
- reg_des_dat_o  out  32  to register file reg_des_dat_i
- busy_o  out  32  scoreboard; bit r set = write to xr in flight
- alloc_err_o  out  1  sticky protocol-violation flag

## Operation
- Handshake: transfer on requester k when req_valid_i[k] && req_ready_o[k]. req_ready_o is combinational from req_valid_i and the RR pointer. The output stage never back-pressures, so at most one grant per cycle and any valid requester is eventually granted.
- Requester obligations: hold valid, rd and data stable until ready. Dropping valid before the grant is allowed.
- Round-robin: search order starts at ptr, then ptr+1 … mod NREQ. The first valid requester wins. After a grant to k, ptr <= (k+1) mod NREQ. With no grant, ptr holds. Reset ptr = 0.
- Output stage: on a grant, wr_en_o <= (rd != 0), reg_des_o <= rd, reg_des_dat_o <= data. With no grant, wr_en_o <= 0, and reg_des_o / reg_des_dat_o hold their last value.
- x0: a request with rd = 0 is granted normally (it consumes the slot and advances ptr) but produces wr_en_o = 0.
- Scoreboard set: alloc_en_i with alloc_rd_i != 0 sets busy[alloc_rd_i] at the next edge. Allocating x0 is ignored. busy_o[0] is always 0.
- Scoreboard clear: busy[reg_des_o] clears at the edge that ends the cycle in which wr_en_o = 1. This is the same edge at which the file captures the data, so busy drops exactly when the new value becomes readable.
- Simultaneous set and clear of the same register: set wins, and busy stays 1.
- Allocating a register whose busy bit is already 1, with no clear of it this cycle, sets alloc_err_o. The bit stays 1. alloc_err_o is sticky until reset. The issue stage must stall on busy; this controller does not.
- A write-back to a register that is not busy is legal: it writes, and busy stays 0.

## Timing
- Reset (async, immediate): wr_en_o=0, reg_des_o=0, reg_des_dat_o=0, busy_o=0, alloc_err_o=0, ptr=0. Reset asserted mid-operation drops any registered write: wr_en_o goes low immediately and the write is not performed.
- Grant to port latency: a grant in cycle N drives the port in cycle N+1. The register file holds the new value from cycle N+2.
- Scoreboard latency: an alloc in cycle N gives busy=1 from N+1. A grant in N gives busy=0 from N+2.
- Throughput: one write per cycle sustained, back-to-back grants allowed.

## Test plan
- Reset then idle → all outputs 0, and req_ready_o=000 with no valid.
- Single requester: req_valid_i=001, rd=5, data=0xDEADBEEF in cycle N → req_ready_o=001 in N. In N+1, wr_en_o=1, reg_des_o=5, reg_des_dat_o=0xDEADBEEF. The file reads x5=0xDEADBEEF in N+2.
- Fairness: all three valid for 6 cycles, each holding on grant → grants in order 0,1,2,0,1,2, one per cycle, with wr_en_o high every cycle from the second cycle on.
- Scoreboard: alloc rd=7 in cycle 1 → busy_o[7]=1 from cycle 2. Write-back rd=7 granted in cycle 4 → busy_o[7]=0 from cycle 6. Alloc rd=7 in cycle 5, coinciding with the clear → busy_o[7] stays 1, and alloc_err_o stays 0.
- x0 and error: request rd=0 → granted, wr_en_o stays 0. alloc rd=0 → busy unchanged. alloc rd=3 twice without a write-back → alloc_err_o=1 and it stays 1.
- Reset mid-write: assert rst_n=0 while wr_en_o=1 with busy_o[9]=1 → wr_en_o, busy_o and ptr clear asynchronously, and x9 is not written.
